cpu_debug_scan_master: RTL and testbench

CPU_DEBUG_SCAN_MASTER -- requirements
Module: cpu_debug_scan_master

---
 rtl/cpu_debug_scan_master_pkg.sv | 30 +++
 rtl/cpu_debug_scan_tck_gen.sv | 55 +++++
 rtl/cpu_debug_scan_master.sv | 175 +++++++++++++++++
 tb/tb_cpu_debug_scan_master.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_debug_scan_master_pkg.sv
// Shared definitions for the CPU debug scan master.
// - state_e: scan FSM states
// - Default scan geometry and the scan latency constants
package cpu_debug_scan_master_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StUir,
    StCdr,
    StSdr,
    StUdr,
    StDone
  } state_e;

  localparam int unsigned DefDrWidth = 38;
  localparam int unsigned DefIrWidth = 2;
  localparam int unsigned DefTckHalf = 2;

  // UIR, CDR and UDR each take one tck period on top of the DR_WIDTH SDR periods.
  localparam int unsigned ScanFixedPeriods = 3;
  // Clk cycles per TCK_HALF from acceptance to rsp_valid, excluding the +1 cycle (82 by default).
  localparam int unsigned DefLatencyFactor = 2 * (DefDrWidth + ScanFixedPeriods);

  // Clk cycles from the acceptance cycle to the cycle in which rsp_valid is first high.
  function automatic int unsigned scan_latency(input int unsigned dr_width,
                                               input int unsigned tck_half);
    return 2 * tck_half * (dr_width + ScanFixedPeriods) + 1;
  endfunction

endpackage

// File: rtl/cpu_debug_scan_tck_gen.sv
// tck divider for the debug scan master.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   enable      - run the divider; low clears tck and the half-period counter
//   tck         - divided clock, starts low, toggles every TCK_HALF clk cycles
//   rise_tick   - one clk wide, high in the cycle whose closing edge raises tck
//   fall_tick   - one clk wide, high in the cycle whose closing edge lowers tck
module cpu_debug_scan_tck_gen #(
  parameter int unsigned TCK_HALF = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tck,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int unsigned CntW = (TCK_HALF > 1) ? $clog2(TCK_HALF) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tck_q, tck_d;
  logic            half_done;

  assign half_done = (cnt_q == CntW'(TCK_HALF - 1));

  always_comb begin
    cnt_d = cnt_q;
    tck_d = tck_q;
    if (!enable) begin
      cnt_d = '0;
      tck_d = 1'b0;
    end else if (half_done) begin
      cnt_d = '0;
      tck_d = ~tck_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

  assign tck       = tck_q;
  assign rise_tick = enable & half_done & ~tck_q;
  assign fall_tick = enable & half_done & tck_q;

endmodule

// File: rtl/cpu_debug_scan_master.sv
// Virtual-JTAG scan master: takes one {IR, DR} command, plays UIR/CDR/SDR/UDR toward
// the debug slave on a divided tck and returns the captured tdo bits.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_ir/cmd_data   - scan command handshake
//   rsp_valid/rsp_ready/rsp_data/rsp_ir_out - scan result handshake
//   vji_tck/tdi/uir/cdr/sdr/udr/rti/ir_in - stimulus toward the debug slave
//   vji_tdo, vji_ir_out             - slave returns
module cpu_debug_scan_master
  import cpu_debug_scan_master_pkg::*;
#(
  parameter int unsigned DR_WIDTH = DefDrWidth,
  parameter int unsigned IR_WIDTH = DefIrWidth,
  parameter int unsigned TCK_HALF = DefTckHalf
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_data,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                vji_tck,
  output logic                vji_tdi,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic                vji_tdo,
  input  logic [IR_WIDTH-1:0] vji_ir_out
);

  localparam int unsigned BitW = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;

  state_e              state_q, state_d;
  logic [DR_WIDTH-1:0] shift_q, shift_d;
  logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
  logic [IR_WIDTH-1:0] ir_out_q, ir_out_d;
  logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
  logic                tdi_q, tdi_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                uir_q, uir_d;
  logic                cdr_q, cdr_d;
  logic                sdr_q, sdr_d;
  logic                udr_q, udr_d;
  logic                rti_q, rti_d;

  logic tck_en, rise_tick, fall_tick;

  assign tck_en = (state_q == StUir) || (state_q == StCdr) ||
                  (state_q == StSdr) || (state_q == StUdr);

  cpu_debug_scan_tck_gen #(
    .TCK_HALF(TCK_HALF)
  ) u_tck_gen (
    .clk      (clk),
    .reset    (reset),
    .enable   (tck_en),
    .tck      (vji_tck),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    ir_in_d   = ir_in_q;
    ir_out_d  = ir_out_q;
    bit_cnt_d = bit_cnt_q;
    tdi_d     = tdi_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready_q) begin
          ir_in_d = cmd_ir;
          shift_d = cmd_data;
          state_d = StUir;
        end
      end
      StUir: begin
        if (fall_tick) state_d = StCdr;
      end
      StCdr: begin
        if (rise_tick) ir_out_d = vji_ir_out;
        if (fall_tick) state_d = StSdr;
      end
      StSdr: begin
        if (rise_tick) begin
          shift_d               = shift_q >> 1;
          shift_d[DR_WIDTH-1]   = vji_tdo;
        end
        if (fall_tick) begin
          if (bit_cnt_q == BitW'(DR_WIDTH - 1)) begin
            bit_cnt_d = '0;
            state_d   = StUdr;
          end else begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
          end
        end
      end
      StUdr: begin
        if (fall_tick) state_d = StDone;
      end
      StDone: begin
        if (rsp_ready && rsp_valid_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // tdi only moves with tck falling. The fall that ends CDR presents bit 0, each SDR
    // fall presents the next bit (already shifted on the preceding rise), and the fall
    // that leaves SDR parks the line low.
    if (fall_tick) tdi_d = (state_d == StSdr) ? shift_q[0] : 1'b0;

    // Outputs are registered copies of the next state, so they line up with state_q.
    cmd_ready_d = (state_d == StIdle);
    rti_d       = (state_d == StIdle);
    uir_d       = (state_d == StUir);
    cdr_d       = (state_d == StCdr);
    sdr_d       = (state_d == StSdr);
    udr_d       = (state_d == StUdr);
    rsp_valid_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      ir_in_q     <= '0;
      ir_out_q    <= '0;
      bit_cnt_q   <= '0;
      tdi_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      uir_q       <= 1'b0;
      cdr_q       <= 1'b0;
      sdr_q       <= 1'b0;
      udr_q       <= 1'b0;
      rti_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      ir_in_q     <= ir_in_d;
      ir_out_q    <= ir_out_d;
      bit_cnt_q   <= bit_cnt_d;
      tdi_q       <= tdi_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      uir_q       <= uir_d;
      cdr_q       <= cdr_d;
      sdr_q       <= sdr_d;
      udr_q       <= udr_d;
      rti_q       <= rti_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = shift_q;
  assign rsp_ir_out = ir_out_q;
  assign vji_tdi    = tdi_q;
  assign vji_uir    = uir_q;
  assign vji_cdr    = cdr_q;
  assign vji_sdr    = sdr_q;
  assign vji_udr    = udr_q;
  assign vji_rti    = rti_q;
  assign vji_ir_in  = ir_in_q;

endmodule

// File: tb/tb_cpu_debug_scan_master.sv
// Self-checking bench for cpu_debug_scan_master: a behavioural virtual-JTAG slave
// answers the scans; results are compared against values derived from the scan rules.
module tb_cpu_debug_scan_master;

  localparam int DR = 38;
  localparam int IR = 2;
  localparam int H  = 2;
  // One tck period each for UIR/CDR/UDR plus DR periods of SDR, then one cycle into DONE.
  localparam int LAT = 2 * H * (DR + 3) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [IR-1:0] cmd_ir = '0;
  logic [DR-1:0] cmd_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DR-1:0] rsp_data;
  logic [IR-1:0] rsp_ir_out;
  logic          vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;
  logic [IR-1:0] vji_ir_in;
  logic          vji_tdo;
  logic [IR-1:0] vji_ir_out = '0;

  int checks = 0;
  int failures = 0;

  cpu_debug_scan_master #(
    .DR_WIDTH(DR),
    .IR_WIDTH(IR),
    .TCK_HALF(H)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_ir    (cmd_ir),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_ir_out(rsp_ir_out),
    .vji_tck   (vji_tck),
    .vji_tdi   (vji_tdi),
    .vji_uir   (vji_uir),
    .vji_cdr   (vji_cdr),
    .vji_sdr   (vji_sdr),
    .vji_udr   (vji_udr),
    .vji_rti   (vji_rti),
    .vji_ir_in (vji_ir_in),
    .vji_tdo   (vji_tdo),
    .vji_ir_out(vji_ir_out)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural debug slave ----------------
  logic [DR-1:0] slave_pre = '0;   // bits returned on tdo, bit 0 first
  logic [DR-1:0] slave_recv = '0;  // tdi bits received, first in bit 0
  logic [IR-1:0] slave_ir_seen = '0;
  int            slave_idx = 0;
  bit            slave_pend = 0;

  assign vji_tdo = (slave_idx < DR) ? slave_pre[slave_idx] : 1'b0;

  always @(posedge vji_tck) begin
    if (vji_uir) slave_ir_seen = vji_ir_in;
    if (vji_cdr) begin
      slave_idx  = 0;
      slave_recv = '0;
    end
    if (vji_sdr && slave_idx < DR) begin
      slave_recv[slave_idx] = vji_tdi;
      slave_pend = 1;
    end
  end

  always @(negedge vji_tck) begin
    if (slave_pend) begin
      slave_idx++;
      slave_pend = 0;
    end
  end

  // ---------------- strobe length / tdi timing monitor ----------------
  // Sampled on posedge: values seen are the ones set by the previous edge.
  int   run_uir = 0, run_cdr = 0, run_sdr = 0, run_udr = 0;
  int   len_uir = 0, len_cdr = 0, len_sdr = 0, len_udr = 0;
  int   tdi_bad = 0;
  logic prev_tdi = 1'b0, prev_tck = 1'b0, prev_rst = 1'b1;

  always @(posedge clk) begin
    if (!prev_rst && (vji_tdi !== prev_tdi) && !(prev_tck && !vji_tck)) tdi_bad++;
    prev_tdi = vji_tdi;
    prev_tck = vji_tck;
    prev_rst = reset;
    if (vji_uir) run_uir++; else if (run_uir != 0) begin len_uir = run_uir; run_uir = 0; end
    if (vji_cdr) run_cdr++; else if (run_cdr != 0) begin len_cdr = run_cdr; run_cdr = 0; end
    if (vji_sdr) run_sdr++; else if (run_sdr != 0) begin len_sdr = run_sdr; run_sdr = 0; end
    if (vji_udr) run_udr++; else if (run_udr != 0) begin len_udr = run_udr; run_udr = 0; end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_reset_outputs(input string tag);
    chk({tag, " cmd_ready"}, 64'(cmd_ready), 64'd1);
    chk({tag, " vji_rti"}, 64'(vji_rti), 64'd1);
    chk({tag, " rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, " rsp_data"}, 64'(rsp_data), 64'd0);
    chk({tag, " rsp_ir_out"}, 64'(rsp_ir_out), 64'd0);
    chk({tag, " vji_ir_in"}, 64'(vji_ir_in), 64'd0);
    chk({tag, " tck/tdi/uir/cdr/sdr/udr"},
        64'({vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr}), 64'd0);
  endtask

  // Wait (at negedges) for rsp_valid; returns the number of cycles waited.
  task automatic wait_rsp(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!rsp_valid && cyc < 4000);
  endtask

  task automatic check_result(input string tag, input logic [IR-1:0] ir, input logic [DR-1:0] data,
                              input logic [DR-1:0] pre, input logic [IR-1:0] iro);
    // tdo bits arrive in slave order; first captured lands in bit 0, so result == preload.
    chk({tag, " rsp_data"}, 64'(rsp_data), 64'(pre));
    chk({tag, " rsp_ir_out"}, 64'(rsp_ir_out), 64'(iro));
    chk({tag, " slave tdi bits"}, 64'(slave_recv), 64'(data));
    chk({tag, " slave ir at uir"}, 64'(slave_ir_seen), 64'(ir));
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk({tag, " idle cmd_ready/rti/rsp_valid"}, 64'({cmd_ready, vji_rti, rsp_valid}), 64'b110);
  endtask

  task automatic run_scan(input string tag, input logic [IR-1:0] ir, input logic [DR-1:0] data,
                          input logic [DR-1:0] pre, input logic [IR-1:0] iro, input bit bp);
    int  cyc;
    bit  stable;
    logic [DR-1:0] held;
    slave_pre     = pre;
    vji_ir_out    = iro;
    slave_ir_seen = ~ir;
    len_uir = 0; len_cdr = 0; len_sdr = 0; len_udr = 0;
    @(negedge clk);
    cmd_ir = ir; cmd_data = data; cmd_valid = 1'b1;
    chk({tag, " cmd_ready before accept"}, 64'(cmd_ready), 64'd1);
    @(posedge clk);
    // Scramble the command inputs: they must have been sampled at acceptance only.
    #1 cmd_valid = 1'b0; cmd_ir = ~ir; cmd_data = ~data;
    @(negedge clk);
    chk({tag, " busy cmd_ready/rti/uir"}, 64'({cmd_ready, vji_rti, vji_uir}), 64'b001);
    wait_rsp(cyc);
    chk({tag, " latency"}, 64'(cyc + 1), 64'(LAT));
    check_result(tag, ir, data, pre, iro);
    if (bp) begin
      cmd_valid = 1'b1; cmd_data = data ^ 38'h15_5555_5555;
      held = rsp_data; stable = 1;
      repeat (10) begin
        @(negedge clk);
        if (!rsp_valid || rsp_data !== held || cmd_ready || vji_uir || vji_tck) stable = 0;
      end
      chk({tag, " backpressure hold"}, 64'(stable), 64'd1);
      cmd_valid = 1'b0;
    end
    handshake(tag);
    chk({tag, " uir len"}, 64'(len_uir), 64'(2 * H));
    chk({tag, " cdr len"}, 64'(len_cdr), 64'(2 * H));
    chk({tag, " sdr len"}, 64'(len_sdr), 64'(2 * H * DR));
    chk({tag, " udr len"}, 64'(len_udr), 64'(2 * H));
  endtask

  typedef struct {
    logic [IR-1:0] ir;
    logic [DR-1:0] data;
    logic [DR-1:0] pre;
    logic [IR-1:0] iro;
    bit            bp;
  } vec_t;

  initial begin
    vec_t vecs[4];
    logic [63:0] r1, r2;
    int   cyc;
    bit   saw_rsp;

    vecs[0] = '{ir: 2'b01, data: 38'h2A_5555_AAAA, pre: 38'h3F_0000_FFFF, iro: 2'b10, bp: 1};
    vecs[1] = '{ir: 2'b11, data: '0,               pre: '1,               iro: 2'b01, bp: 0};
    vecs[2] = '{ir: 2'b00, data: '1,               pre: '0,               iro: 2'b11, bp: 0};
    vecs[3] = '{ir: 2'b10, data: 38'h20_0000_0001, pre: 38'h00_8000_0003, iro: 2'b00, bp: 0};

    // Reset for 3 cycles.
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_reset_outputs("reset");
    reset = 1'b0;

    for (int i = 0; i < 4; i++) run_scan($sformatf("vec%0d", i), vecs[i].ir, vecs[i].data,
                                         vecs[i].pre, vecs[i].iro, vecs[i].bp);

    for (int i = 0; i < 3; i++) begin
      r1 = {$urandom(), $urandom()};
      r2 = {$urandom(), $urandom()};
      run_scan($sformatf("rand%0d", i), IR'($urandom_range(0, 3)), r1[DR-1:0], r2[DR-1:0],
               IR'($urandom_range(0, 3)), 0);
    end

    // Reset in the middle of SDR, after bit 20 has been shifted.
    slave_pre = 38'h12_3456_789A; vji_ir_out = 2'b11;
    @(negedge clk);
    cmd_ir = 2'b11; cmd_data = 38'h0F_F0F0_0F0F; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cyc = 0;
    while (!(vji_sdr && slave_idx > 20) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("midsdr reached bit 20", 64'(vji_sdr && slave_idx > 20), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check_idle_reset_outputs("midsdr reset");
    reset = 1'b0;
    saw_rsp = 0;
    repeat (LAT + 20) begin
      @(negedge clk);
      if (rsp_valid || vji_uir) saw_rsp = 1;
    end
    chk("aborted scan no response", 64'(saw_rsp), 64'd0);
    run_scan("after abort", 2'b10, 38'h33_CCCC_3333, 38'h05_A5A5_5A5A, 2'b01, 0);

    // Back-to-back commands with rsp_ready held high.
    slave_pre = 38'h2D_DEAD_BEEF; vji_ir_out = 2'b01;
    rsp_ready = 1'b1;
    @(negedge clk);
    cmd_ir = 2'b01; cmd_data = 38'h11_1111_1111; cmd_valid = 1'b1;
    wait_rsp(cyc);
    chk("b2b first latency", 64'(cyc), 64'(LAT));
    check_result("b2b first", 2'b01, 38'h11_1111_1111, 38'h2D_DEAD_BEEF, 2'b01);
    cmd_ir = 2'b10; cmd_data = 38'h22_2222_2222;
    // Handshake at the coming edge; the second command must be taken on the edge after it.
    @(negedge clk);
    chk("b2b ready after handshake", 64'({cmd_ready, rsp_valid}), 64'b10);
    @(negedge clk);
    chk("b2b second accepted", 64'({cmd_ready, vji_uir}), 64'b01);
    cmd_valid = 1'b0;
    wait_rsp(cyc);
    chk("b2b second latency", 64'(cyc + 1), 64'(LAT));
    check_result("b2b second", 2'b10, 38'h22_2222_2222, 38'h2D_DEAD_BEEF, 2'b01);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("b2b back to idle", 64'({cmd_ready, vji_rti, rsp_valid}), 64'b110);

    chk("tdi moves only on tck fall", 64'(tdi_bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
